// File: rtl/serial_boot_loader.sv
// Serial boot loader: assembles framed UART bytes into little-endian 32-bit words and writes
// them into the processor data RAM, holding the processor in reset while a frame is in flight.
module serial_boot_loader #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  cpu_wEn,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_dataIn,
    output logic                  ram_wEn,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_dataIn,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           words_written
);

    localparam int unsigned    TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR0, S_ADDR1, S_CNT0, S_CNT1, S_DATA, S_CHK
    } state_t;

    state_t state, state_next;

    logic [7:0]            addr_lo;
    logic [7:0]            cnt_lo;
    logic [7:0]            chk;
    logic [15:0]           word_count;
    logic [1:0]            byte_idx;
    logic [23:0]           word_buf;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wr_data;
    logic                  wr_en;
    logic [TW-1:0]         idle_cnt;

    logic [15:0] addr_full;
    logic [15:0] count_full;
    logic        addr_bad;
    logic        last_word;
    logic        timeout_hit;

    assign addr_full   = {rx_data, addr_lo};
    assign count_full  = {rx_data, cnt_lo};
    assign addr_bad    = (addr_full >> ADDR_WIDTH) != 16'd0;
    assign last_word   = (words_written + 16'd1) == word_count;
    assign timeout_hit = (state != S_IDLE) && !rx_valid && (idle_cnt == T_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        if (timeout_hit) begin
            state_next = S_IDLE;
        end else if (rx_valid) begin
            case (state)
                S_IDLE:  if (rx_data == SYNC_BYTE) state_next = S_ADDR0;
                S_ADDR0: state_next = S_ADDR1;
                S_ADDR1: state_next = addr_bad ? S_IDLE : S_CNT0;
                S_CNT0:  state_next = S_CNT1;
                S_CNT1:  state_next = (count_full == 16'd0) ? S_CHK : S_DATA;
                S_DATA:  if (byte_idx == 2'd3 && last_word) state_next = S_CHK;
                S_CHK:   state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Datapath: the write is registered so it lands one clock after the 4th data byte,
    // and the address advances on that write cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_lo       <= '0;
            cnt_lo        <= '0;
            chk           <= '0;
            word_count    <= '0;
            byte_idx      <= '0;
            word_buf      <= '0;
            addr          <= '0;
            wr_data       <= '0;
            wr_en         <= 1'b0;
            idle_cnt      <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            words_written <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (wr_en) addr <= addr + ADDR_WIDTH'(1);

            if (state == S_IDLE || rx_valid) begin
                idle_cnt <= '0;
            end else if (timeout_hit) begin
                idle_cnt <= '0;
                err      <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end

            if (rx_valid) begin
                if (state inside {S_ADDR0, S_ADDR1, S_CNT0, S_CNT1, S_DATA}) chk <= chk ^ rx_data;
                case (state)
                    S_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            err           <= 1'b0;
                            words_written <= '0;
                            chk           <= '0;
                            byte_idx      <= '0;
                        end
                    end
                    S_ADDR0: addr_lo <= rx_data;
                    S_ADDR1: begin
                        if (addr_bad) err  <= 1'b1;
                        else          addr <= addr_full[ADDR_WIDTH-1:0];
                    end
                    S_CNT0: cnt_lo <= rx_data;
                    S_CNT1: begin
                        word_count <= count_full;
                        byte_idx   <= '0;
                    end
                    S_DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    word_buf[7:0]   <= rx_data;
                            2'd1:    word_buf[15:8]  <= rx_data;
                            2'd2:    word_buf[23:16] <= rx_data;
                            default: begin
                                wr_en         <= 1'b1;
                                wr_data       <= {rx_data, word_buf};
                                words_written <= words_written + 16'd1;
                            end
                        endcase
                    end
                    S_CHK: begin
                        if (rx_data == chk) done <= 1'b1;
                        else                err  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        busy       = (state != S_IDLE);
        cpu_hold   = busy;
        ram_wEn    = cpu_wEn;
        ram_addr   = cpu_addr;
        ram_dataIn = cpu_dataIn;
        if (busy) begin
            ram_wEn    = wr_en;
            ram_addr   = addr;
            ram_dataIn = wr_data;
        end
    end

endmodule

// File: tb/tb_serial_boot_loader.sv
// Directed bench for serial_boot_loader: frames, checksum errors, address wrap, bad address,
// timeout, mid-frame reset and idle passthrough.
module tb_serial_boot_loader;

    localparam int AW = 12;

    logic          clock      = 1'b0;
    logic          reset      = 1'b1;
    logic          rx_valid   = 1'b0;
    logic [7:0]    rx_data    = '0;
    logic          cpu_wEn    = 1'b0;
    logic [AW-1:0] cpu_addr   = '0;
    logic [31:0]   cpu_dataIn = '0;
    logic          ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_dataIn;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   words_written;

    int checks   = 0;
    int passes   = 0;
    int done_cnt = 0;
    logic          sync_err;
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [7:0]    frame_q[$];

    serial_boot_loader #(
        .ADDR_WIDTH    (AW),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .cpu_wEn      (cpu_wEn),
        .cpu_addr     (cpu_addr),
        .cpu_dataIn   (cpu_dataIn),
        .ram_wEn      (ram_wEn),
        .ram_addr     (ram_addr),
        .ram_dataIn   (ram_dataIn),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_written(words_written)
    );

    always #5 clock = ~clock;

    // RAM-side observer: logs loader writes and counts done pulses, once per clock.
    always @(negedge clock) begin
        if (busy === 1'b1 && ram_wEn === 1'b1) begin
            wr_addr_q.push_back(ram_addr);
            wr_data_q.push_back(ram_dataIn);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; the byte is sampled on the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
    endtask

    // Sends frame_q back-to-back followed by its checksum XORed with corrupt.
    task automatic send_frame(input logic [7:0] corrupt);
        logic [7:0] c = '0;
        int drops = 0;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i > 0) c ^= frame_q[i];
            send_byte(frame_q[i]);
            if (i == 0) sync_err = err;
            if (busy !== 1'b1) drops++;
        end
        send_byte(c ^ corrupt);
        rx_valid = 1'b0;
        check("busy_held_in_frame", drops, 0);
    endtask

    initial begin
        int wbase;
        int dbase;

        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_words", words_written, 0);
        check("rst_ram_wEn", ram_wEn, 0);

        // Idle passthrough is combinational
        cpu_wEn = 1'b1; cpu_addr = 12'h123; cpu_dataIn = 32'hDEADBEEF;
        #1;
        check("pass_wEn", ram_wEn, 1);
        check("pass_addr", ram_addr, 12'h123);
        check("pass_data", ram_dataIn, 32'hDEADBEEF);
        @(negedge clock);
        cpu_wEn = 1'b0; cpu_addr = '0; cpu_dataIn = '0;

        // Non-SYNC bytes in IDLE
        send_byte(8'h00); send_byte(8'h5A); send_byte(8'hA4);
        rx_valid = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_err", err, 0);
        check("idle_words", words_written, 0);
        check("idle_done", done, 0);

        // Good frame at 0x010, two words
        wbase = wr_addr_q.size(); dbase = done_cnt;
        frame_q = {8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'h55, 8'h66, 8'h77, 8'h88};
        send_frame(8'h00);
        check("A_busy_end", busy, 0);
        check("A_done", done, 1);
        check("A_err", err, 0);
        check("A_words", words_written, 2);
        @(negedge clock);
        check("A_done_one_clock", done, 0);
        check("A_done_count", done_cnt - dbase, 1);
        check("A_write_count", wr_addr_q.size() - wbase, 2);
        check("A_addr0", wr_addr_q[wbase], 12'h010);
        check("A_data0", wr_data_q[wbase], 32'h44332211);
        check("A_addr1", wr_addr_q[wbase + 1], 12'h011);
        check("A_data1", wr_data_q[wbase + 1], 32'h88776655);

        // Same frame, bad checksum
        wbase = wr_addr_q.size(); dbase = done_cnt;
        send_frame(8'hFF);
        check("B_busy_end", busy, 0);
        check("B_done", done, 0);
        check("B_err", err, 1);
        @(negedge clock);
        check("B_done_count", done_cnt - dbase, 0);
        check("B_write_count", wr_addr_q.size() - wbase, 2);
        check("B_data1", wr_data_q[wbase + 1], 32'h88776655);

        // Non-SYNC bytes leave the sticky error and counts alone
        send_byte(8'h00); send_byte(8'h33);
        rx_valid = 1'b0;
        check("idle2_err", err, 1);
        check("idle2_words", words_written, 2);
        check("idle2_busy", busy, 0);

        // Wrap from 0xFFF to 0x000; SYNC clears err
        wbase = wr_addr_q.size();
        frame_q = {8'hA5, 8'hFF, 8'h0F, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                   8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(8'h00);
        check("W_err_at_sync", sync_err, 0);
        check("W_done", done, 1);
        check("W_err", err, 0);
        @(negedge clock);
        check("W_write_count", wr_addr_q.size() - wbase, 2);
        check("W_addr0", wr_addr_q[wbase], 12'hFFF);
        check("W_data0", wr_data_q[wbase], 32'h04030201);
        check("W_addr1", wr_addr_q[wbase + 1], 12'h000);
        check("W_data1", wr_data_q[wbase + 1], 32'h08070605);

        // Address high byte 0x10 is out of range
        wbase = wr_addr_q.size();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
        rx_valid = 1'b0;
        check("H_busy", busy, 0);
        check("H_err", err, 1);
        @(negedge clock);
        check("H_write_count", wr_addr_q.size() - wbase, 0);

        // Timeout: stop after two data bytes
        wbase = wr_addr_q.size();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        rx_valid = 1'b0;
        check("T_err_cleared", err, 0);
        repeat (99) @(negedge clock);
        check("T_busy_at_99", busy, 1);
        @(negedge clock);
        check("T_busy_at_100", busy, 0);
        check("T_err_at_100", err, 1);
        check("T_write_count", wr_addr_q.size() - wbase, 0);

        // Reset mid-frame, with the processor still requesting a write
        wbase = wr_addr_q.size();
        cpu_wEn = 1'b1; cpu_addr = 12'h123; cpu_dataIn = 32'hDEADBEEF;
        send_byte(8'hA5);
        check("R_loader_owns_port", ram_wEn, 0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        check("R_words_before", words_written, 1);
        rx_valid = 1'b1; rx_data = 8'h77; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; rx_valid = 1'b0;
        check("R_busy", busy, 0);
        check("R_cpu_hold", cpu_hold, 0);
        check("R_done", done, 0);
        check("R_err", err, 0);
        check("R_words", words_written, 0);
        check("R_ram_wEn", ram_wEn, 1);
        check("R_ram_addr", ram_addr, 12'h123);
        check("R_ram_data", ram_dataIn, 32'hDEADBEEF);
        check("R_write_count", wr_addr_q.size() - wbase, 1);
        cpu_wEn = 1'b0;

        // Zero-count frame goes straight to the checksum
        wbase = wr_addr_q.size();
        frame_q = {8'hA5, 8'h34, 8'h01, 8'h00, 8'h00};
        send_frame(8'h00);
        check("Z_done", done, 1);
        check("Z_err", err, 0);
        check("Z_words", words_written, 0);
        @(negedge clock);
        check("Z_write_count", wr_addr_q.size() - wbase, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_boot_loader.md
# serial_boot_loader

Receives framed program/data images byte-by-byte from the UART receiver, assembles them into 32-bit little-endian words and writes them into the processor data RAM through its primary write port. While a frame is in progress it owns that RAM port and holds the processor in reset. Outside a frame it passes the processor's RAM signals through untouched. It sits between processor, UART_simple and RAM in the top level, alongside MemoryMap.

## Interface
- ADDR_WIDTH, 12, RAM word-address width.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame.

Ports:
- clock  in  1  system clock; the block has one clock.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte (same clock domain).
- rx_data  in  8  received byte.
- cpu_wEn  in  1  processor RAM write enable.
- cpu_addr  in  ADDR_WIDTH  processor RAM address.
- cpu_dataIn  in  32  processor RAM write data.
- ram_wEn  out  1  to RAM wEn.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_dataIn  out  32  to RAM dataIn.
- cpu_hold  out  1  ORed into the processor reset; high while a frame is active.
- busy  out  1  frame in progress; same value as cpu_hold.
- done  out  1  one-cycle pulse on a good frame end.
- err  out  1  sticky error flag; cleared at next SYNC acceptance or reset.
- words_written  out  16  words written in the current or last frame.

## Operation
- States: IDLE, ADDR0, ADDR1, CNT0, CNT1, DATA, CHK. State advances only on rx_valid, except timeout.
- IDLE: ignores every byte other than SYNC_BYTE. SYNC clears err, words_written, the checksum and the byte index, sets busy, and enters ADDR0.
- ADDR0 / ADDR1: start address low byte, then high byte. Bits above ADDR_WIDTH must be 0. A nonzero upper bit sets err and returns to IDLE.
- CNT0 / CNT1: 16-bit word count, low byte first. Count 0 goes straight to CHK; otherwise go to DATA.
- DATA: bytes fill word[7:0], [15:8], [23:16], [31:24] in order. On the 4th byte, the word is written to the current address. The address then increments, wrapping from 2^ADDR_WIDTH-1 to 0. words_written increments. After the count-th word, go to CHK.
- CHK: the byte is compared with the XOR of all bytes from ADDR0 through the last data byte.
  - Match: pulse done.
  - Mismatch: set err; done stays low.
  - Either way, return to IDLE and clear busy. RAM writes already made are not undone.
- Timeout: in any non-IDLE state, TIMEOUT_CYCLES clocks with no rx_valid sets err and returns to IDLE. The counter reloads on every rx_valid.
- RAM mux:
  - busy=0: ram_wEn/ram_addr/ram_dataIn = cpu_wEn/cpu_addr/cpu_dataIn, combinationally.
  - busy=1: the loader drives the port, and ram_wEn is high only on its write cycle.
- A SYNC_BYTE received inside a frame is ordinary data, not a restart.
- reset mid-frame: the frame is abandoned, no write is issued, and all state returns to reset values.

## Timing
- Reset values: state IDLE, busy=cpu_hold=0, done=0, err=0, words_written=0, address=0, timeout counter=0. RAM outputs follow the cpu_* inputs.
- busy rises the clock after the SYNC strobe. It falls the clock after the CHK strobe, error exit or timeout.
- Word write: ram_wEn is high for exactly one clock, the clock after the rx_valid carrying byte 3. ram_addr and ram_dataIn are stable in that cycle.
- done is high in the same clock busy falls, for one clock.
- The largest frame is 65535 words. The address wraps modulo 2^ADDR_WIDTH; there is no error for wrap.
- Back-to-back rx_valid on consecutive clocks is supported with no byte loss.
- rx_valid asserted in the same clock as reset is ignored.

## Test plan
- Good frame A5 10 00 02 00 | 11 22 33 44 | 55 66 77 88 | CHK=XOR(10,00,02,00,11..88):
  - Expected: RAM[0x010]=0x44332211 and RAM[0x011]=0x88776655.
  - Expected: done pulses once, err=0, words_written=2.
  - Expected: cpu_hold is high from the clock after A5 until done.
- Same frame with CHK wrong:
  - Expected: both words written, err=1, done never high, busy=0 afterwards.
  - Then a new good frame: err clears on its SYNC.
- Address 0xFFF with count 2:
  - Expected: writes land at 0xFFF then 0x000.
- Address high byte 0x10: err=1, return to IDLE, no RAM write.
- Stop sending after 2 data bytes, with TIMEOUT_CYCLES=100 for the test:
  - Expected: err=1 and busy=0 exactly 100 clocks after the last strobe, no write.
  - Then assert reset mid-frame in a second run: all outputs return to reset values the next clock.
- Idle passthrough:
  - With busy=0, cpu_wEn=1, cpu_addr=0x123, cpu_dataIn=0xDEADBEEF: RAM port shows the same values in the same cycle.
  - Non-SYNC bytes in IDLE do not change any output.
